// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// =============================================================================
// Module : mem_bus_ctrl
// Desc   : Processor-side memory bus initiator; arbitrates fetch/data clients,
//          tracks outstanding load tags and routes returned data to its owner.
// Rev    : 1.0  initial release
// =============================================================================
module mem_bus_ctrl #(
    parameter int XLEN    = 32,
    parameter int MAX_OUT = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_req_valid,
    input  logic [XLEN-1:0] if_req_addr,
    input  logic [3:0]      if_req_id,
    output logic            if_req_ready,
    output logic            if_resp_valid,
    output logic [3:0]      if_resp_id,
    output logic [63:0]     if_resp_data,
    input  logic            d_req_valid,
    input  logic [1:0]      d_req_cmd,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic [63:0]     d_req_data,
    input  logic [1:0]      d_req_size,
    input  logic [3:0]      d_req_id,
    output logic            d_req_ready,
    output logic            d_resp_valid,
    output logic [3:0]      d_resp_id,
    output logic [63:0]     d_resp_data,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic [1:0]      proc2mem_size,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [3:0]      outstanding,
    output logic            spurious_tag
);

    localparam logic [1:0] c_BUS_NONE  = 2'd0;
    localparam logic [1:0] c_BUS_LOAD  = 2'd1;
    localparam logic [1:0] c_BUS_STORE = 2'd2;
    localparam logic [1:0] c_DOUBLE    = 2'd3;
    localparam logic [3:0] c_MAX_OUT   = 4'(MAX_OUT);

    logic        r_prio_q, r_prio_d;
    logic [3:0]  r_out_q, r_out_d;
    logic [15:0] r_tv_q, r_tv_d;
    logic [15:0] r_town_q, r_town_d;
    logic [3:0]  r_tid_q [16];
    logic [3:0]  r_tid_d [16];

    logic        r_if_rv_q, r_d_rv_q, r_spur_q;
    logic [3:0]  r_if_rid_q, r_d_rid_q;
    logic [63:0] r_if_rdata_q, r_d_rdata_q;

    logic w_load_ok, w_if_elig, w_d_elig, w_gnt_if, w_gnt_d;
    logic w_accept, w_alloc, w_ret, w_ret_hit;

    // Stores bypass the outstanding-load limit since they never hold a tag.
    assign w_load_ok = (r_out_q < c_MAX_OUT);
    assign w_if_elig = if_req_valid & w_load_ok;
    assign w_d_elig  = d_req_valid & ((d_req_cmd == c_BUS_STORE) | w_load_ok);
    assign w_gnt_if  = w_if_elig & (~w_d_elig | ~r_prio_q);
    assign w_gnt_d   = w_d_elig & ~w_gnt_if;

    assign w_accept  = (w_gnt_if | w_gnt_d) & (mem2proc_response != 4'd0);
    assign w_alloc   = w_accept & (w_gnt_if | (d_req_cmd == c_BUS_LOAD));
    assign w_ret     = (mem2proc_tag != 4'd0);
    assign w_ret_hit = w_ret & r_tv_q[mem2proc_tag];

    assign if_req_ready = w_gnt_if & w_accept;
    assign d_req_ready  = w_gnt_d & w_accept;

    always_comb begin
        proc2mem_command = c_BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_size    = 2'd0;
        if (w_gnt_if) begin
            proc2mem_command = c_BUS_LOAD;
            proc2mem_addr    = if_req_addr;
            proc2mem_size    = c_DOUBLE;
        end else if (w_gnt_d) begin
            proc2mem_command = d_req_cmd;
            proc2mem_addr    = d_req_addr;
            proc2mem_data    = d_req_data;
            proc2mem_size    = d_req_size;
        end
    end

    always_comb begin
        r_prio_d = r_prio_q;
        if (w_gnt_if | w_gnt_d) begin
            r_prio_d = w_accept ? w_gnt_if : w_gnt_d;
        end

        r_out_d = r_out_q;
        if (w_alloc & ~w_ret_hit) begin
            r_out_d = r_out_q + 4'd1;
        end else if (~w_alloc & w_ret_hit) begin
            r_out_d = r_out_q - 4'd1;
        end

        // Retire before allocate so a reused tag ends up owned by the new load.
        r_tv_d   = r_tv_q;
        r_town_d = r_town_q;
        r_tid_d  = r_tid_q;
        if (w_ret_hit) begin
            r_tv_d[mem2proc_tag] = 1'b0;
        end
        if (w_alloc) begin
            r_tv_d[mem2proc_response]   = 1'b1;
            r_town_d[mem2proc_response] = w_gnt_d;
            r_tid_d[mem2proc_response]  = w_gnt_d ? d_req_id : if_req_id;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prio_q     <= 1'b0;
            r_out_q      <= 4'd0;
            r_tv_q       <= '0;
            r_town_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                r_tid_q[i] <= 4'd0;
            end
            r_if_rv_q    <= 1'b0;
            r_d_rv_q     <= 1'b0;
            r_spur_q     <= 1'b0;
            r_if_rid_q   <= 4'd0;
            r_d_rid_q    <= 4'd0;
            r_if_rdata_q <= '0;
            r_d_rdata_q  <= '0;
        end else begin
            r_prio_q  <= r_prio_d;
            r_out_q   <= r_out_d;
            r_tv_q    <= r_tv_d;
            r_town_q  <= r_town_d;
            r_tid_q   <= r_tid_d;
            r_if_rv_q <= w_ret_hit & ~r_town_q[mem2proc_tag];
            r_d_rv_q  <= w_ret_hit & r_town_q[mem2proc_tag];
            r_spur_q  <= w_ret & ~r_tv_q[mem2proc_tag];
            if (w_ret_hit & ~r_town_q[mem2proc_tag]) begin
                r_if_rid_q   <= r_tid_q[mem2proc_tag];
                r_if_rdata_q <= mem2proc_data;
            end
            if (w_ret_hit & r_town_q[mem2proc_tag]) begin
                r_d_rid_q   <= r_tid_q[mem2proc_tag];
                r_d_rdata_q <= mem2proc_data;
            end
        end
    end

    assign if_resp_valid = r_if_rv_q;
    assign if_resp_id    = r_if_rid_q;
    assign if_resp_data  = r_if_rdata_q;
    assign d_resp_valid  = r_d_rv_q;
    assign d_resp_id     = r_d_rid_q;
    assign d_resp_data   = r_d_rdata_q;
    assign outstanding   = r_out_q;
    assign spurious_tag  = r_spur_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// =============================================================================
// Module : tb_mem_bus_ctrl
// Desc   : Vector table plus randomized run against a transaction-level model.
// Rev    : 1.0  initial release
// =============================================================================
module tb_mem_bus_ctrl;

    localparam int MAXO = 2;
    localparam logic [1:0] N  = 2'd0;
    localparam logic [1:0] L  = 2'd1;
    localparam logic [1:0] S  = 2'd2;
    localparam logic [1:0] DB = 2'd3;
    localparam int NV = 24;

    logic        clock, reset;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [31:0] if_req_addr;
    logic [3:0]  if_req_id, if_resp_id;
    logic [63:0] if_resp_data;
    logic        d_req_valid, d_req_ready, d_resp_valid;
    logic [1:0]  d_req_cmd, d_req_size;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_data, d_resp_data;
    logic [3:0]  d_req_id, d_resp_id;
    logic [1:0]  proc2mem_command, proc2mem_size;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data, mem2proc_data;
    logic [3:0]  mem2proc_response, mem2proc_tag, outstanding;
    logic        spurious_tag;

    mem_bus_ctrl #(.XLEN(32), .MAX_OUT(MAXO)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_id(if_req_id),
        .if_req_ready(if_req_ready), .if_resp_valid(if_resp_valid), .if_resp_id(if_resp_id),
        .if_resp_data(if_resp_data),
        .d_req_valid(d_req_valid), .d_req_cmd(d_req_cmd), .d_req_addr(d_req_addr),
        .d_req_data(d_req_data), .d_req_size(d_req_size), .d_req_id(d_req_id),
        .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid), .d_resp_id(d_resp_id),
        .d_resp_data(d_resp_data),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag), .outstanding(outstanding), .spurious_tag(spurious_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        ifv;  logic [31:0] ifa; logic [3:0] ifid;
        logic        dv;   logic [1:0]  dcmd; logic [31:0] da; logic [63:0] dd;
        logic [1:0]  dsz;  logic [3:0]  did;
        logic [3:0]  rsp;  logic [3:0]  tag; logic [63:0] rdat;
        logic        e_ifr; logic e_dr; logic [1:0] e_cmd; logic [31:0] e_addr;
        logic [63:0] e_bdata; logic [1:0] e_bsz;
        logic [3:0]  e_out; logic e_ifrv; logic e_drv; logic [3:0] e_rid; logic e_spur;
    } vec_t;

    vec_t tbl [NV];
    int   n_vec = 0;
    int   n_bad = 0;

    // Transaction-level model state: which tags are in flight and for whom.
    bit         m_val [16];
    bit         m_own [16];
    logic [3:0] m_id  [16];
    int         m_cnt;
    bit         m_prio;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    task automatic apply_vec(input vec_t v, input string nm);
        reset             = v.rst;
        if_req_valid      = v.ifv;  if_req_addr = v.ifa; if_req_id = v.ifid;
        d_req_valid       = v.dv;   d_req_cmd   = v.dcmd; d_req_addr = v.da;
        d_req_data        = v.dd;   d_req_size  = v.dsz;  d_req_id   = v.did;
        mem2proc_response = v.rsp;  mem2proc_tag = v.tag; mem2proc_data = v.rdat;
        @(negedge clock);
        chk({nm, ".if_ready"}, 64'(if_req_ready),     64'(v.e_ifr));
        chk({nm, ".d_ready"},  64'(d_req_ready),      64'(v.e_dr));
        chk({nm, ".cmd"},      64'(proc2mem_command), 64'(v.e_cmd));
        chk({nm, ".addr"},     64'(proc2mem_addr),    64'(v.e_addr));
        chk({nm, ".bdata"},    proc2mem_data,         v.e_bdata);
        chk({nm, ".bsize"},    64'(proc2mem_size),    64'(v.e_bsz));
        @(posedge clock); #1;
        chk({nm, ".outstanding"}, 64'(outstanding),   64'(v.e_out));
        chk({nm, ".if_rv"},       64'(if_resp_valid), 64'(v.e_ifrv));
        chk({nm, ".d_rv"},        64'(d_resp_valid),  64'(v.e_drv));
        chk({nm, ".spurious"},    64'(spurious_tag),  64'(v.e_spur));
        if (v.e_ifrv) begin
            chk({nm, ".if_rid"},   64'(if_resp_id), 64'(v.e_rid));
            chk({nm, ".if_rdata"}, if_resp_data,    v.rdat);
        end
        if (v.e_drv) begin
            chk({nm, ".d_rid"},   64'(d_resp_id), 64'(v.e_rid));
            chk({nm, ".d_rdata"}, d_resp_data,    v.rdat);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_val[i] = 1'b0; m_own[i] = 1'b0; m_id[i] = 4'd0;
        end
        m_cnt  = 0;
        m_prio = 1'b0;
    endtask

    // Builds one random cycle and fills in the expectations from the model.
    task automatic gen_random(output vec_t v);
        bit gi, gd, lo;
        int r;
        v.rst  = ($urandom_range(0, 99) == 0);
        v.ifv  = 1'($urandom_range(0, 1));
        v.ifa  = 32'($urandom);
        v.ifid = 4'($urandom);
        v.dv   = 1'($urandom_range(0, 1));
        v.dcmd = ($urandom_range(0, 1) == 0) ? L : S;
        v.da   = 32'($urandom);
        v.dd   = {32'($urandom), 32'($urandom)};
        v.dsz  = 2'($urandom);
        v.did  = 4'($urandom);
        v.rdat = {32'($urandom), 32'($urandom)};
        r = $urandom_range(0, 9);
        if (r < 5 && m_cnt > 0) begin
            int t;
            t = $urandom_range(1, 15);
            while (!m_val[t]) t = (t % 15) + 1;
            v.tag = 4'(t);
        end else if (r == 5) begin
            v.tag = 4'($urandom_range(1, 15));
        end else begin
            v.tag = 4'd0;
        end
        if ($urandom_range(0, 3) == 0) begin
            v.rsp = 4'd0;
        end else begin
            int t;
            t = $urandom_range(1, 15);
            while (m_val[t] && (4'(t) != v.tag)) t = (t % 15) + 1;
            v.rsp = 4'(t);
        end

        lo = (m_cnt < MAXO);
        gi = v.ifv && lo;
        gd = v.dv && (v.dcmd == S || lo);
        if (gi && gd) begin
            gi = !m_prio;
            gd = m_prio;
        end
        v.e_cmd = N; v.e_addr = 0; v.e_bdata = 0; v.e_bsz = 0;
        if (gi) begin
            v.e_cmd = L; v.e_addr = v.ifa; v.e_bsz = DB;
        end else if (gd) begin
            v.e_cmd = v.dcmd; v.e_addr = v.da; v.e_bdata = v.dd; v.e_bsz = v.dsz;
        end
        v.e_ifr = gi && (v.rsp != 0);
        v.e_dr  = gd && (v.rsp != 0);

        v.e_ifrv = 0; v.e_drv = 0; v.e_rid = 0; v.e_spur = 0;
        if (v.rst) begin
            model_clear();
        end else begin
            if (v.tag != 0) begin
                if (m_val[v.tag]) begin
                    if (m_own[v.tag]) v.e_drv = 1; else v.e_ifrv = 1;
                    v.e_rid = m_id[v.tag];
                    m_val[v.tag] = 1'b0;
                    m_cnt--;
                end else begin
                    v.e_spur = 1;
                end
            end
            if ((gi || gd) && v.rsp != 0) begin
                m_prio = gi;
                if (gi || v.dcmd == L) begin
                    m_val[v.rsp] = 1'b1;
                    m_own[v.rsp] = gd;
                    m_id[v.rsp]  = gi ? v.ifid : v.did;
                    m_cnt++;
                end
            end else if (gi || gd) begin
                m_prio = gd;
            end
        end
        v.e_out = 4'(m_cnt);
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{0, 0,0,0, 0,N,0,0,0,0, 0,0,0, 0,0,N,0,0,0, 0,0,0,0,0};
        tbl[1]  = '{0, 1,32'h100,5, 0,N,0,0,0,0, 3,0,0, 1,0,L,32'h100,0,DB, 1,0,0,0,0};
        tbl[2]  = '{0, 0,0,0, 0,N,0,0,0,0, 0,3,64'hDEADBEEF_00000013, 0,0,N,0,0,0, 0,1,0,5,0};
        tbl[3]  = '{0, 0,0,0, 1,S,32'h200,64'h55,DB,1, 7,0,0, 0,1,S,32'h200,64'h55,DB, 0,0,0,0,0};
        tbl[4]  = '{0, 1,32'h300,2, 1,L,32'h400,0,2'd2,6, 1,0,0, 1,0,L,32'h300,0,DB, 1,0,0,0,0};
        tbl[5]  = '{0, 1,32'h300,2, 1,L,32'h400,0,2'd2,6, 2,0,0, 0,1,L,32'h400,0,2'd2, 2,0,0,0,0};
        tbl[6]  = '{0, 0,0,0, 0,N,0,0,0,0, 0,2,64'hA, 0,0,N,0,0,0, 1,0,1,6,0};
        tbl[7]  = '{0, 0,0,0, 0,N,0,0,0,0, 0,1,64'hB, 0,0,N,0,0,0, 0,1,0,2,0};
        tbl[8]  = '{0, 1,32'h500,3, 0,N,0,0,0,0, 5,0,0, 1,0,L,32'h500,0,DB, 1,0,0,0,0};
        tbl[9]  = '{0, 1,32'h510,4, 1,S,32'h600,64'h77,DB,9, 0,0,0, 0,0,S,32'h600,64'h77,DB, 1,0,0,0,0};
        tbl[10] = '{0, 1,32'h510,4, 1,S,32'h600,64'h77,DB,9, 4,0,0, 0,1,S,32'h600,64'h77,DB, 1,0,0,0,0};
        tbl[11] = '{0, 1,32'h510,4, 0,N,0,0,0,0, 6,0,0, 1,0,L,32'h510,0,DB, 2,0,0,0,0};
        tbl[12] = '{0, 1,32'h520,7, 0,N,0,0,0,0, 9,0,0, 0,0,N,0,0,0, 2,0,0,0,0};
        tbl[13] = '{0, 1,32'h520,7, 1,S,32'h700,64'h1,DB,2, 8,0,0, 0,1,S,32'h700,64'h1,DB, 2,0,0,0,0};
        tbl[14] = '{0, 1,32'h520,7, 1,L,32'h800,0,DB,1, 3,0,0, 0,0,N,0,0,0, 2,0,0,0,0};
        tbl[15] = '{0, 1,32'h520,7, 0,N,0,0,0,0, 2,5,64'hC, 0,0,N,0,0,0, 1,1,0,3,0};
        tbl[16] = '{0, 1,32'h520,7, 0,N,0,0,0,0, 6,6,64'hD, 1,0,L,32'h520,0,DB, 1,1,0,4,0};
        tbl[17] = '{0, 0,0,0, 0,N,0,0,0,0, 0,6,64'hE, 0,0,N,0,0,0, 0,1,0,7,0};
        tbl[18] = '{0, 0,0,0, 0,N,0,0,0,0, 0,9,64'h9, 0,0,N,0,0,0, 0,0,0,0,1};
        tbl[19] = '{0, 0,0,0, 0,N,0,0,0,0, 0,0,0, 0,0,N,0,0,0, 0,0,0,0,0};
        tbl[20] = '{0, 1,32'h900,8, 0,N,0,0,0,0, 2,0,0, 1,0,L,32'h900,0,DB, 1,0,0,0,0};
        tbl[21] = '{1, 0,0,0, 0,N,0,0,0,0, 0,0,0, 0,0,N,0,0,0, 0,0,0,0,0};
        tbl[22] = '{0, 0,0,0, 0,N,0,0,0,0, 0,2,64'hF, 0,0,N,0,0,0, 0,0,0,0,1};
        tbl[23] = '{0, 0,0,0, 0,N,0,0,0,0, 0,0,0, 0,0,N,0,0,0, 0,0,0,0,0};

        reset = 1'b1;
        if_req_valid = 0; if_req_addr = 0; if_req_id = 0;
        d_req_valid = 0; d_req_cmd = N; d_req_addr = 0; d_req_data = 0;
        d_req_size = 0; d_req_id = 0;
        mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
        @(posedge clock);
        @(posedge clock); #1;
        chk("rst.if_ready",    64'(if_req_ready),     64'd0);
        chk("rst.d_ready",     64'(d_req_ready),      64'd0);
        chk("rst.cmd",         64'(proc2mem_command), 64'(N));
        chk("rst.if_rv",       64'(if_resp_valid),    64'd0);
        chk("rst.if_rid",      64'(if_resp_id),       64'd0);
        chk("rst.if_rdata",    if_resp_data,          64'd0);
        chk("rst.d_rv",        64'(d_resp_valid),     64'd0);
        chk("rst.d_rid",       64'(d_resp_id),        64'd0);
        chk("rst.d_rdata",     d_resp_data,           64'd0);
        chk("rst.outstanding", 64'(outstanding),      64'd0);
        chk("rst.spurious",    64'(spurious_tag),     64'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply_vec(tbl[i], $sformatf("row%0d", i));
        end

        // Randomized traffic from a clean reset, checked against the model.
        reset = 1'b1;
        if_req_valid = 0; d_req_valid = 0; mem2proc_response = 0; mem2proc_tag = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 400; i++) begin
            gen_random(v);
            apply_vec(v, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
